// File: rtl/steel_dmem.sv
// steel_dmem: byte-maskable data RAM with registered write-first loads and sticky out-of-range error tracking.
// Define STEEL_DMEM_CLEAR_EN to zero the array word-by-word after every reset (BUSY high meanwhile).
module steel_dmem #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] DATA_OUT,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  output logic [31:0] DATA_IN,
  output logic        BUSY,
  output logic        OOR_ERR,
  output logic [7:0]  ERR_COUNT
);
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] offset, rd_word, merged, data_in_q, data_in_d;
  logic [DEPTH_LOG2-1:0] idx, clr_idx;
  logic in_range, we, busy, store_err, read_err, oor_err_q, oor_err_d;
  logic [7:0] err_count_q, err_count_d;
`ifdef STEEL_DMEM_CLEAR_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  logic [0:0] state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
  always_comb begin
    busy      = state_q == S_CLEAR;
    state_d   = (busy && &clr_idx_q) ? S_IDLE : state_q;
    clr_idx_d = busy ? clr_idx_q + 1'b1 : clr_idx_q;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  assign clr_idx = clr_idx_q;
`else
  assign busy    = 1'b0;
  assign clr_idx = '0;
`endif
  always_comb begin
    offset    = D_ADDR - BASE_ADDR;
    in_range  = offset < (32'd4 << DEPTH_LOG2);
    idx       = offset[DEPTH_LOG2+1:2];
    rd_word   = mem[idx];
    merged    = rd_word;
    for (int i = 0; i < 4; i++)
      if (WR_MASK[i]) merged[8*i+:8] = DATA_OUT[8*i+:8];
    we        = WR_REQ && !busy && in_range;
    // Load and store share D_ADDR, so a concurrent store always hits the word being read.
    data_in_d = (busy || !in_range) ? 32'h0 : (WR_REQ ? merged : rd_word);
    store_err = !in_range && WR_REQ && |WR_MASK && !busy;
    read_err  = !in_range && !WR_REQ;
    oor_err_d = oor_err_q || store_err || read_err;
    err_count_d = (store_err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge CLK) begin
    if (busy) mem[clr_idx] <= '0;
    else if (we) mem[idx] <= merged;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_in_q   <= '0;
      oor_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      data_in_q   <= data_in_d;
      oor_err_q   <= oor_err_d;
      err_count_q <= err_count_d;
    end
  end
  assign DATA_IN   = data_in_q;
  assign BUSY      = busy;
  assign OOR_ERR   = oor_err_q;
  assign ERR_COUNT = err_count_q;
endmodule

// File: tb/tb_steel_dmem.sv
// tb_steel_dmem: randomized and directed checks of steel_dmem against an array-based reference model.
module tb_steel_dmem;
  localparam int          DL    = 4;
  localparam int          WORDS = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  logic CLK = 1'b0, RESET = 1'b0, WR_REQ = 1'b0, BUSY, OOR_ERR;
  logic [31:0] D_ADDR = '0, DATA_OUT = '0, DATA_IN;
  logic [3:0] WR_MASK = '0;
  logic [7:0] ERR_COUNT;
  int checks = 0, failures = 0;
  logic [31:0] mem_m [WORDS];
  bit kn [WORDS];
  logic [31:0] ed = '0;
  bit dk = 1, eo = 0;
  int ec = 0, busy_left = 0;
`ifdef STEEL_DMEM_CLEAR_EN
  localparam bit CLR = 1;
`else
  localparam bit CLR = 0;
`endif
  steel_dmem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .D_ADDR(D_ADDR), .DATA_OUT(DATA_OUT), .WR_REQ(WR_REQ),
    .WR_MASK(WR_MASK), .DATA_IN(DATA_IN), .BUSY(BUSY), .OOR_ERR(OOR_ERR), .ERR_COUNT(ERR_COUNT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m);
    logic [31:0] off;
    int wi;
    D_ADDR = a; DATA_OUT = d; WR_REQ = w; WR_MASK = m;
    off = a - BASE;
    wi = int'(off[5:2]);
    if (busy_left > 0) begin
      mem_m[WORDS - busy_left] = '0;
      kn[WORDS - busy_left] = 1;
      busy_left--;
      ed = '0; dk = 1;
      if (off >= 64 && !w) eo = 1;
    end else if (off < 64) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (m[i]) mem_m[wi][8*i+:8] = d[8*i+:8];
        if (m == 4'hF) kn[wi] = 1;
      end
      ed = mem_m[wi]; dk = kn[wi];
    end else begin
      ed = '0; dk = 1;
      if (w && m != 0) begin
        eo = 1;
        if (ec != 255) ec++;
      end else if (!w) eo = 1;
    end
    @(posedge CLK); #1;
    if (dk) chk("data", DATA_IN, ed);
    chk("oor", 32'(OOR_ERR), 32'(eo));
    chk("cnt", 32'(ERR_COUNT), ec);
    chk("busy", 32'(BUSY), 32'(busy_left > 0));
  endtask
  task automatic do_reset();
    WR_REQ = 0; WR_MASK = 0;
    @(negedge CLK);
    RESET = 0;
    #1;
    chk("rst_data", DATA_IN, 32'h0);
    chk("rst_oor", 32'(OOR_ERR), 32'h0);
    chk("rst_cnt", 32'(ERR_COUNT), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'(CLR));
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1;
    ed = '0; dk = 1; eo = 0; ec = 0;
    busy_left = CLR ? WORDS : 0;
    if (CLR) begin mem_m[0] = '0; kn[0] = 1; end
  endtask
  task automatic busy_run();
    int n = 0;
    while (BUSY && n < 100) begin
      step(BASE + 32'($urandom_range(0, 63)), $urandom, 1'b1, 4'hF);
      n++;
    end
    chk("busy_len", n, WORDS);
  endtask
  initial begin
    for (int i = 0; i < WORDS; i++) begin mem_m[i] = '0; kn[i] = 0; end
    do_reset();
    if (CLR) begin
      busy_run();
      for (int i = 0; i < WORDS; i++) step(BASE + 32'(4 * i), '0, 1'b0, 4'h0);
    end
    step(BASE + 32'h10, 32'hDEADBEEF, 1'b1, 4'hF);
    step(BASE + 32'h10, 32'h0, 1'b0, 4'h0);
    chk("deadbeef", DATA_IN, 32'hDEADBEEF);
    step(BASE + 32'h13, 32'h000000AA, 1'b1, 4'b0001);
    step(BASE + 32'h10, 32'h0, 1'b0, 4'h0);
    chk("byte_merge", DATA_IN, 32'hDEADBEAA);
    step(BASE + 32'h20, 32'h12345678, 1'b1, 4'hF);
    chk("write_first", DATA_IN, 32'h12345678);
    step(BASE + 32'h20, 32'hFFFFFFFF, 1'b1, 4'h0);
    chk("mask0", DATA_IN, 32'h12345678);
    chk("mask0_oor", 32'(OOR_ERR), 32'h0);
    step(BASE + 32'h40, 32'h11111111, 1'b1, 4'hF);
    chk("oor_store_flag", 32'(OOR_ERR), 32'h1);
    chk("oor_store_cnt", 32'(ERR_COUNT), 32'h1);
    step(BASE + 32'h0, 32'h11111111, 1'b1, 4'hF);
    step(BASE + 32'h40, 32'h0, 1'b0, 4'h0);
    chk("oor_read_zero", DATA_IN, 32'h0);
    step(BASE - 32'h4, 32'h0, 1'b0, 4'h0);
    step(BASE - 32'h4, 32'h5, 1'b1, 4'h0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? BASE + 32'($urandom_range(64, 200)) : BASE + 32'($urandom_range(0, 63));
      step(a, $urandom, 1'($urandom), 4'($urandom));
    end
    for (int i = 0; i < 300; i++) step(BASE + 32'h40 + 32'($urandom_range(0, 255)), $urandom, 1'b1, 4'hF);
    chk("cnt_sat", 32'(ERR_COUNT), 32'hFF);
    for (int i = 0; i < WORDS; i++) step(BASE + 32'(4 * i), '0, 1'b0, 4'h0);
    if (CLR) begin
      do_reset();
      for (int i = 0; i < 7; i++) step(BASE + 32'h40, 32'h0, 1'b0, 4'h0);
      do_reset();
      busy_run();
      for (int i = 0; i < WORDS; i++) step(BASE + 32'(4 * i), '0, 1'b0, 4'h0);
    end else begin
      do_reset();
      step(BASE + 32'h10, 32'h0, 1'b0, 4'h0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/steel_dmem.md
STEEL_DMEM -- requirements
Module: steel_dmem

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, giving log2 of the number of 32-bit words (4096 words = 16 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port D_ADDR, input, 32 bits: byte address from the core.
REQ-006 SHALL have port DATA_OUT, input, 32 bits: store data from the core.
REQ-007 SHALL have port WR_REQ, input, 1 bit: store request.
REQ-008 SHALL have port WR_MASK, input, 4 bits: byte enables, where bit i covers DATA_OUT[8i+7:8i].
REQ-009 SHALL have port DATA_IN, output, 32 bits: registered load data to the core.
REQ-010 SHALL have port BUSY, output, 1 bit: high while the clear sequence runs.
REQ-011 SHALL have port OOR_ERR, output, 1 bit: sticky out-of-range access flag.
REQ-012 SHALL have port ERR_COUNT, output, 8 bits: saturating count of out-of-range stores.

Function
REQ-013 SHALL compute offset = D_ADDR - BASE_ADDR (32-bit, wrapping) and word index = offset[DEPTH_LOG2+1:2]; an access is in range iff offset < 4*2^DEPTH_LOG2.
REQ-014 SHALL ignore D_ADDR[1:0] for indexing; byte placement is defined solely by WR_MASK.
REQ-015 SHALL, on an in-range store (WR_REQ=1, BUSY=0), write exactly the bytes whose WR_MASK bit is 1 at the rising edge and leave the other bytes unchanged.
REQ-016 SHALL treat WR_REQ=1 with WR_MASK=4'b0000 as a no-op store that does not count as an error.
REQ-017 SHALL register DATA_IN every cycle with one-cycle latency: DATA_IN at cycle N+1 = word at the index of D_ADDR sampled at cycle N.
REQ-018 SHALL be write-first: when a cycle stores to the index being read, DATA_IN on the next cycle shows the merged new word.
REQ-019 SHALL load DATA_IN with 32'h0 on an out-of-range read, and SHALL also do so on any cycle where BUSY=1.
REQ-020 SHALL suppress an out-of-range store (memory unchanged), set OOR_ERR=1 on the next edge, and increment ERR_COUNT, saturating at 8'hFF.
REQ-021 SHALL set OOR_ERR on an out-of-range read only when WR_REQ=0, and SHALL not increment ERR_COUNT for it.
REQ-022 SHALL keep OOR_ERR and ERR_COUNT sticky until reset; there is no software clear.
REQ-023 SHALL ignore all stores while BUSY=1 and SHALL not flag them as errors.

Reset
REQ-024 SHALL, while RESET=0, immediately force DATA_IN=0, OOR_ERR=0 and ERR_COUNT=0.
REQ-025 SHALL not reset memory array contents through RESET; the array is cleared only by the sequence in REQ-027.
REQ-026 SHALL restart the clear sequence from word 0 when reset is asserted during a clear.

Configuration
REQ-027 SHALL, with macro STEEL_DMEM_CLEAR_EN defined, run a two-state FSM: CLEAR is entered on reset, writes 0 to one word per cycle using an index counter from 0 to 2^DEPTH_LOG2-1, then goes to IDLE after the last word; BUSY=1 in CLEAR, exactly 2^DEPTH_LOG2 cycles after RESET rises.
REQ-028 SHALL, with STEEL_DMEM_CLEAR_EN undefined, omit the FSM and counter, tie BUSY=0, and leave memory contents unspecified after reset.

Verification
REQ-029 SHALL cover: store 32'hDEADBEEF at 0x10 mask 4'hF, then load 0x10 -> DATA_IN=32'hDEADBEEF one cycle after the load address.
REQ-030 SHALL cover: over word 0x10=32'hDEADBEEF, store 32'h000000AA mask 4'b0001 -> read returns 32'hDEADBEAA.
REQ-031 SHALL cover: same-cycle store 32'h12345678 mask 4'hF and read of 0x20 -> next DATA_IN=32'h12345678.
REQ-032 SHALL cover: store to BASE_ADDR+4*2^DEPTH_LOG2 -> no memory change, OOR_ERR=1, ERR_COUNT=1; 300 such stores -> ERR_COUNT=8'hFF.
REQ-033 SHALL cover, with CLEAR_EN and DEPTH_LOG2=4: release reset -> BUSY high for 16 cycles, every word reads 0, and stores during BUSY are dropped.
REQ-034 SHALL cover: assert RESET mid-clear at index 7 -> DATA_IN, OOR_ERR and ERR_COUNT immediately 0, and the clear restarts at index 0 with 16 BUSY cycles.
